// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packet sequencer.
package usb_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_DRAIN,
      ST_EOP,
      ST_DONE
   } tx_state_t;

   localparam logic [7:0] SYNC_LAST_BYTE = 8'h80;
   localparam logic [7:0] SYNC_FILL_BYTE = 8'h00;

   // SYNC is all fill bytes except the final one, giving line order 0...01.
   function automatic logic [7:0] sync_byte(logic [1:0] idx, logic [1:0] last_idx);
      return (idx == last_idx) ? SYNC_LAST_BYTE : SYNC_FILL_BYTE;
   endfunction

endpackage

// File: rtl/usb_tx_stage.sv
// One-deep staging register between the packet builder and the sequencer.
module usb_tx_stage (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       accept_en,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   input  logic       take,
   output logic       in_ready,
   output logic       stage_valid,
   output logic [7:0] stage_data,
   output logic       stage_last
);

   assign in_ready = accept_en && !stage_valid;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         stage_valid <= 1'b0;
         stage_data  <= '0;
         stage_last  <= 1'b0;
      end else if (in_valid && in_ready) begin
         stage_valid <= 1'b1;
         stage_data  <= in_data;
         stage_last  <= in_last;
      end else if (take) begin
         stage_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB transmit sequencer: SYNC, staged payload, stuffer drain and SE0 EOP,
// with truncation flagging on underrun or length overflow.
module usb_tx_sequencer
   import usb_tx_pkg::*;
#(
   parameter int SYNC_BITS = 8,
   parameter int MAX_BYTES = 1026,
   parameter int EOP_BITS  = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           tx_start,
   input  logic [7:0]                     in_data,
   input  logic                           in_valid,
   input  logic                           in_last,
   output logic                           in_ready,
   output logic                           piso_load,
   output logic [7:0]                     piso_data,
   input  logic                           piso_done,
   input  logic                           stuffer_done,
   output logic                           nrzi_enable,
   output logic                           se0,
   output logic                           tx_busy,
   output logic                           tx_done,
   output logic                           tx_err,
   output logic [$clog2(MAX_BYTES+1)-1:0] byte_count
);

   localparam int SYNC_BYTES = SYNC_BITS / 8;
   localparam int CNT_W      = $clog2(MAX_BYTES + 1);
   localparam int EOP_W      = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;

   localparam logic [1:0]       SYNC_LAST_IDX = 2'(SYNC_BYTES - 1);
   localparam logic [7:0]       SYNC_FIRST    = sync_byte(2'd0, SYNC_LAST_IDX);
   localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(MAX_BYTES);
   localparam logic [EOP_W-1:0] EOP_RELOAD    = EOP_W'(EOP_BITS - 1);

   tx_state_t        state;
   logic [1:0]       sync_idx;
   logic [EOP_W-1:0] eop_cnt;
   logic             first_load;
   logic             err;
   logic             payload_closed;
   logic             stage_valid;
   logic             stage_last;
   logic [7:0]       stage_data;
   logic             accept_en;
   logic             take;
   logic             done_load;
   logic [7:0]       load_byte;

   assign accept_en = (state == ST_SYNC || state == ST_DATA) && !payload_closed;

   usb_tx_stage u_stage (
      .clk         (clk),
      .rst         (rst),
      .clr         (state == ST_DONE),
      .accept_en   (accept_en),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .take        (take),
      .in_ready    (in_ready),
      .stage_valid (stage_valid),
      .stage_data  (stage_data),
      .stage_last  (stage_last)
   );

   // Loads issued on piso_done are combinational so the next byte follows
   // with zero idle bits; only the SYNC entry load comes from a register.
   always_comb begin
      done_load = 1'b0;
      load_byte = '0;
      take      = 1'b0;
      if (piso_done) begin
         case (state)
            ST_SYNC: begin
               if (sync_idx == SYNC_LAST_IDX) begin
                  if (stage_valid) begin
                     done_load = 1'b1;
                     load_byte = stage_data;
                     take      = 1'b1;
                  end
               end else begin
                  done_load = 1'b1;
                  load_byte = sync_byte(sync_idx + 2'd1, SYNC_LAST_IDX);
               end
            end
            ST_DATA: begin
               if (stage_valid && !payload_closed) begin
                  done_load = 1'b1;
                  load_byte = stage_data;
                  take      = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign piso_load = first_load | done_load;
   assign piso_data = first_load ? SYNC_FIRST : load_byte;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         sync_idx       <= '0;
         eop_cnt        <= '0;
         first_load     <= 1'b0;
         err            <= 1'b0;
         payload_closed <= 1'b0;
         nrzi_enable    <= 1'b0;
         se0            <= 1'b0;
         tx_busy        <= 1'b0;
         tx_done        <= 1'b0;
         tx_err         <= 1'b0;
         byte_count     <= '0;
      end else begin
         first_load <= 1'b0;
         tx_done    <= 1'b0;
         tx_err     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tx_start) begin
                  state          <= ST_SYNC;
                  first_load     <= 1'b1;
                  sync_idx       <= '0;
                  byte_count     <= '0;
                  err            <= 1'b0;
                  payload_closed <= 1'b0;
                  tx_busy        <= 1'b1;
                  nrzi_enable    <= 1'b1;
               end
            end
            ST_SYNC: begin
               if (piso_done) begin
                  if (sync_idx != SYNC_LAST_IDX) begin
                     sync_idx <= sync_idx + 2'd1;
                  end else if (stage_valid) begin
                     state <= ST_DATA;
                  end else begin
                     err   <= 1'b1;
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DATA: begin
               if (piso_done && (payload_closed || !stage_valid)) begin
                  if (!payload_closed) err <= 1'b1;
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (stuffer_done) begin
                  state       <= ST_EOP;
                  se0         <= 1'b1;
                  nrzi_enable <= 1'b0;
                  eop_cnt     <= EOP_RELOAD;
               end
            end
            ST_EOP: begin
               if (eop_cnt == '0) begin
                  state   <= ST_DONE;
                  se0     <= 1'b0;
                  tx_done <= 1'b1;
                  tx_err  <= err;
               end else begin
                  eop_cnt <= eop_cnt - 1'b1;
               end
            end
            ST_DONE: begin
               state          <= ST_IDLE;
               tx_busy        <= 1'b0;
               err            <= 1'b0;
               payload_closed <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
         // Payload bookkeeping shared by the SYNC->DATA handoff and DATA loads.
         if (take) begin
            if (byte_count != CNT_MAX) byte_count <= byte_count + 1'b1;
            if (stage_last) begin
               payload_closed <= 1'b1;
            end else if (byte_count == CNT_MAX - 1'b1) begin
               payload_closed <= 1'b1;
               err            <= 1'b1;
            end
         end
      end
   end

endmodule
